// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Counter width is $clog2(width), never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry holding register that lets the next word wait while the shifter is busy.
module piso_hold_reg
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             full
);

    logic [WIDTH-1:0] data_reg;
    logic             full_reg;

    // push only happens while empty and pop only while full, so they never coincide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg <= '0;
            full_reg <= 1'b0;
        end else if (push) begin
            data_reg <= d;
            full_reg <= 1'b1;
        end else if (pop) begin
            full_reg <= 1'b0;
        end
    end

    assign q    = data_reg;
    assign full = full_reg;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-word holding buffer and a bypass path.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] sh_reg, sh_next;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] next_word;
    logic [WIDTH-1:0] next_ord;
    logic             hold_full;
    logic             hold_push;
    logic             hold_pop;
    logic             accept;
    logic             free;

    piso_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk  (clk),
        .rst  (rst),
        .push (hold_push),
        .pop  (hold_pop),
        .d    (load_data),
        .q    (hold_q),
        .full (hold_full)
    );

    assign load_ready = !hold_full;
    assign accept     = load_valid && load_ready;

    assign ser_valid = (state_reg == SHIFT);
    assign ser_first = ser_valid && (cnt_reg == '0);
    assign ser_last  = ser_valid && (cnt_reg == LAST_CNT);
    assign ser_out   = sh_reg[0];

    assign free      = (state_reg == IDLE) || (ser_en && ser_last);
    assign hold_pop  = free && hold_full;
    assign hold_push = accept && !free;

    // A full hold buffer has priority; otherwise a same-edge accept bypasses it.
    assign next_word = hold_full ? hold_q : load_data;

    // The shifter always emits bit 0 first, so reorder the word on the way in.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
            if (MSB_FIRST) begin : g_msb
                assign next_ord[gi] = next_word[WIDTH-1-gi];
            end else begin : g_lsb
                assign next_ord[gi] = next_word[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sh_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sh_reg    <= sh_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sh_next    = sh_reg;
        if (free) begin
            cnt_next = '0;
            if (hold_full || accept) begin
                state_next = SHIFT;
                sh_next    = next_ord;
            end else begin
                state_next = IDLE;
                sh_next    = '0;
            end
        end else if (ser_en) begin
            cnt_next = cnt_reg + CW'(1);
            sh_next  = sh_reg >> 1;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed tables, corner sequences and random loopback.
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         ser_en = 1'b0;

    logic l_ready, l_out, l_valid, l_first, l_last;
    logic m_ready, m_out, m_valid, m_first, m_last;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (l_ready),
        .load_data  (load_data),
        .ser_en     (ser_en),
        .ser_out    (l_out),
        .ser_valid  (l_valid),
        .ser_first  (l_first),
        .ser_last   (l_last)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (m_ready),
        .load_data  (load_data),
        .ser_en     (ser_en),
        .ser_out    (m_out),
        .ser_valid  (m_valid),
        .ser_first  (m_first),
        .ser_last   (m_last)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: words not yet fully sent, and how many bits of the oldest are consumed.
    logic [W-1:0] mq[$];
    int           mpos = 0;

    // Loopback scoreboard
    logic [W-1:0] sbq[$];
    logic [W-1:0] sipo = '0;
    bit           loop_on = 1'b0;
    int           n_acc = 0;
    int           n_lasts = 0;

    typedef struct {
        logic         lv;
        logic [W-1:0] d;
        logic         en;
        logic [4:0]   exp;   // {ready, valid, out, first, last}
    } vec_t;

    vec_t tbl[9];

    function automatic logic [4:0] lsb_vec();
        return {l_ready, l_valid, l_out, l_first, l_last};
    endfunction

    function automatic logic [4:0] msb_vec();
        return {m_ready, m_valid, m_out, m_first, m_last};
    endfunction

    function automatic logic [4:0] model_out(input bit msb);
        logic v, o;
        int   idx;
        v   = (mq.size() > 0);
        idx = msb ? (W - 1 - mpos) : mpos;
        o   = 1'b0;
        if (v) o = mq[0][idx];
        return {(mq.size() < 2), v, o, (v && mpos == 0), (v && mpos == W - 1)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // One enabled-or-not clock cycle: drive, clock, update model, compare both DUTs.
    task automatic step(input logic lv, input logic [W-1:0] d, input logic en, input string tag);
        bit acc;
        load_valid = lv;
        load_data  = d;
        ser_en     = en;
        acc = lv && (mq.size() < 2);
        if (loop_on && en && l_valid) begin
            sipo = {l_out, sipo[W-1:1]};
            if (l_last) begin
                n_lasts++;
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL loop word: got %h expected none", sipo);
                end else begin
                    check("loop word", sipo, sbq.pop_front());
                end
            end
        end
        @(posedge clk);
        if (mq.size() > 0 && en) begin
            mpos++;
            if (mpos == W) begin
                mq.delete(0);
                mpos = 0;
            end
        end
        if (acc) begin
            mq.push_back(d);
            if (loop_on) begin
                sbq.push_back(d);
                n_acc++;
            end
        end
        #1;
        $display("step %s: lv=%b d=%h en=%b acc=%b -> lsb=%b msb=%b", tag, lv, d, en, acc,
                 lsb_vec(), msb_vec());
        check({tag, " lsb"}, lsb_vec(), model_out(1'b0));
        check({tag, " msb"}, msb_vec(), model_out(1'b1));
    endtask

    task automatic model_clear();
        mq.delete();
        mpos = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] seq;

        tbl[0] = '{1'b1, 4'b1100, 1'b1, 5'b11010};
        tbl[1] = '{1'b1, 4'b0011, 1'b1, 5'b01000};
        tbl[2] = '{1'b1, 4'b1111, 1'b1, 5'b01100};
        tbl[3] = '{1'b0, 4'b0000, 1'b1, 5'b01101};
        tbl[4] = '{1'b0, 4'b0000, 1'b1, 5'b11110};
        tbl[5] = '{1'b0, 4'b0000, 1'b1, 5'b11100};
        tbl[6] = '{1'b0, 4'b0000, 1'b1, 5'b11000};
        tbl[7] = '{1'b0, 4'b0000, 1'b1, 5'b11001};
        tbl[8] = '{1'b0, 4'b0000, 1'b1, 5'b10000};

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_clear();
        #1;
        check("reset lsb", lsb_vec(), 5'b10000);
        check("reset msb", msb_vec(), 5'b10000);

        // Single word, bit 0 first
        seq = '0;
        step(1'b1, 4'b1010, 1'b1, "single0");
        seq[0] = l_out;
        for (int i = 1; i < W; i++) begin
            step(1'b0, 4'b0000, 1'b1, "single");
            seq[i] = l_out;
        end
        check("single bits", seq, 4'b1010);
        step(1'b0, 4'b0000, 1'b1, "single_end");
        check("single idle valid", l_valid, 1'b0);

        // Back-to-back words with back-pressure, from the vector table
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].lv, tbl[i].d, tbl[i].en, $sformatf("b2b%0d", i));
            check($sformatf("b2b table %0d", i), lsb_vec(), tbl[i].exp);
        end

        // Stall after the second bit
        step(1'b1, 4'b0110, 1'b1, "stall_load");
        step(1'b0, 4'b0000, 1'b1, "stall_bit1");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0000, 1'b0, "stall_hold");
            check("stall held", {l_valid, l_out, l_first, l_last}, 4'b1100);
        end
        step(1'b0, 4'b0000, 1'b1, "stall_bit2");
        check("stall bit2", {l_valid, l_out, l_last}, 3'b110);
        step(1'b0, 4'b0000, 1'b1, "stall_bit3");
        check("stall bit3", {l_valid, l_out, l_last}, 3'b101);
        step(1'b0, 4'b0000, 1'b1, "stall_done");

        // MSB-first ordering on the second instance
        seq = '0;
        step(1'b1, 4'b1000, 1'b1, "msb0");
        seq = {seq[W-2:0], m_out};
        for (int i = 1; i < W; i++) begin
            step(1'b0, 4'b0000, 1'b1, "msb");
            seq = {seq[W-2:0], m_out};
        end
        check("msb order", seq, 4'b1000);
        step(1'b0, 4'b0000, 1'b1, "msb_end");

        // Asynchronous reset mid-word with the hold buffer full
        step(1'b1, 4'b1111, 1'b1, "rst_w0");
        step(1'b1, 4'b0101, 1'b1, "rst_w1");
        step(1'b0, 4'b0000, 1'b1, "rst_mid");
        rst = 1'b0;
        #2;
        check("async reset lsb", lsb_vec(), 5'b10000);
        check("async reset msb", msb_vec(), 5'b10000);
        @(posedge clk);
        #1 rst = 1'b1;
        model_clear();
        step(1'b0, 4'b0000, 1'b1, "post_rst");
        step(1'b0, 4'b0000, 1'b1, "post_rst");

        // Random loopback through a bench-side SIPO
        loop_on = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (n_acc >= 16 && mq.size() == 0) break;
            step((n_acc < 16) && ($urandom_range(0, 3) != 0), W'($urandom),
                 ($urandom_range(0, 3) != 0), "loop");
        end
        check("loop accepted", n_acc, 16);
        check("loop drained", mq.size(), 0);
        check("loop last count", n_lasts, n_acc);
        check("loop scoreboard empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
